aes_iter_core: RTL

//  Parametrised iterative AES-128 encryption core: UNROLL rounds per clock, on-the-fly key schedule,

---
 rtl/aes_pkg.sv | 75 +++++++
 rtl/aes_round_step.sv | 56 +++++
 rtl/aes_iter_core.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encoding and GF(2^8) helpers for the iterative AES core.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_ROUNDS  = 10;
  localparam int AES_CTR_W   = 128;
  localparam int AES_RND_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ (b[i] ? p : 8'h00);
      p   = xtime(p);
    end
    return acc;
  endfunction

  // S-box built from the field inverse x^254 followed by the FIPS-197 affine map (0 maps to 0x63).
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = gf_mul(x, x);
    for (int i = 1; i < 8; i++) begin
      inv = gf_mul(inv, sq);
      sq  = gf_mul(sq, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [AES_RND_W-1:0] rnd);
    logic [7:0] r;
    case (rnd)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_round_step.sv
// One AES-128 encryption round plus the matching key-expansion step; key_in is round key rnd-1,
// key_out is round key rnd and is also the key added into state_out.
module aes_round_step
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] state_in,
  input  logic [AES_BLOCK_W-1:0] key_in,
  input  logic [AES_RND_W-1:0]   rnd,
  input  logic                   last_round,
  output logic [AES_BLOCK_W-1:0] state_out,
  output logic [AES_BLOCK_W-1:0] key_out
);

  logic [AES_BLOCK_W-1:0] sub_s;
  logic [AES_BLOCK_W-1:0] shift_s;
  logic [AES_BLOCK_W-1:0] mix_s;
  logic [31:0]            temp_s;
  logic [31:0]            w0_s, w1_s, w2_s, w3_s;

  // SubBytes then ShiftRows; byte index is row + 4*column, byte 0 in the top bits.
  always_comb begin
    sub_s   = '0;
    shift_s = '0;
    for (int j = 0; j < 16; j++) begin
      sub_s[127-8*j -: 8] = sbox(state_in[127-8*j -: 8]);
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_s[127-8*(4*c+r) -: 8] = sub_s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
  end

  // MixColumns, bypassed in the final round.
  always_comb begin
    mix_s = shift_s;
    for (int c = 0; c < 4; c++) begin
      mix_s[127-32*c -: 32] = last_round ? shift_s[127-32*c -: 32]
                                         : mix_column(shift_s[127-32*c -: 32]);
    end
  end

  // Key expansion: RotWord, SubWord and Rcon on the last word, then the xor cascade.
  always_comb begin
    temp_s = {sbox(key_in[23:16]), sbox(key_in[15:8]), sbox(key_in[7:0]), sbox(key_in[31:24])}
             ^ {rcon(rnd), 24'h000000};
    w0_s   = key_in[127:96] ^ temp_s;
    w1_s   = key_in[95:64] ^ w0_s;
    w2_s   = key_in[63:32] ^ w1_s;
    w3_s   = key_in[31:0] ^ w2_s;
  end

  assign key_out   = {w0_s, w1_s, w2_s, w3_s};
  assign state_out = mix_s ^ key_out;

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128 encryption core, UNROLL rounds per clock with on-the-fly key schedule.
// Optional counter mode is enabled with the AES_CTR_EN macro.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int UNROLL = 1,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] key_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              busy
`ifdef AES_CTR_EN
  ,
  input  logic                 ctr_load,
  input  logic [AES_CTR_W-1:0] ctr_init
`endif
);

  if (DATA_W != AES_BLOCK_W) begin : g_bad_width
    $fatal(1, "aes_iter_core: DATA_W must be 128");
  end
  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 5) begin : g_bad_unroll
    $fatal(1, "aes_iter_core: UNROLL must be 1, 2 or 5");
  end

  aes_state_e             state_r, state_nxt_s;
  logic [AES_BLOCK_W-1:0] blk_r;
  logic [AES_BLOCK_W-1:0] key_r;
  logic [AES_RND_W-1:0]   rnd_r;
  logic [AES_BLOCK_W-1:0] data_out_r;
  logic                   out_valid_r, in_ready_r, busy_r;
  logic                   out_valid_nxt_s, in_ready_nxt_s, busy_nxt_s;
  logic                   accept_s, finish_s, release_s;
  logic [AES_BLOCK_W-1:0] src_s, out_blk_s;

  logic [AES_BLOCK_W-1:0] st_chain_s  [UNROLL+1];
  logic [AES_BLOCK_W-1:0] key_chain_s [UNROLL+1];

  assign st_chain_s[0]  = blk_r;
  assign key_chain_s[0] = key_r;

  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    logic [AES_RND_W-1:0] rnd_s;
    assign rnd_s = rnd_r + AES_RND_W'(g);
    aes_round_step u_step (
      .state_in   (st_chain_s[g]),
      .key_in     (key_chain_s[g]),
      .rnd        (rnd_s),
      .last_round (rnd_s == AES_RND_W'(AES_ROUNDS)),
      .state_out  (st_chain_s[g+1]),
      .key_out    (key_chain_s[g+1])
    );
  end

  assign accept_s  = (state_r == IDLE) && in_valid && in_ready_r;
  assign finish_s  = (state_r == RUN) &&
                     (rnd_r + AES_RND_W'(UNROLL - 1) == AES_RND_W'(AES_ROUNDS));
  assign release_s = (state_r == DONE) && out_valid_r && out_ready;

`ifdef AES_CTR_EN
  logic [AES_CTR_W-1:0]   ctr_r, ctr_src_s;
  logic [AES_BLOCK_W-1:0] pt_r;

  // A load on the accept edge takes priority, so the block uses ctr_init directly.
  assign ctr_src_s = ctr_load ? ctr_init : ctr_r;
  assign src_s     = ctr_src_s;
  assign out_blk_s = st_chain_s[UNROLL] ^ pt_r;

  // Counter and latched plaintext for the keystream xor.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctr_r <= '0;
      pt_r  <= '0;
    end else if (accept_s) begin
      ctr_r <= ctr_src_s + AES_CTR_W'(1);
      pt_r  <= data_in;
    end else if ((state_r == IDLE) && ctr_load) begin
      ctr_r <= ctr_init;
    end
  end
`else
  assign src_s     = data_in;
  assign out_blk_s = st_chain_s[UNROLL];
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_nxt_s = RUN;  else state_nxt_s = IDLE;
      RUN:     if (finish_s) state_nxt_s = DONE; else state_nxt_s = RUN;
      DONE:    if (release_s) state_nxt_s = IDLE; else state_nxt_s = DONE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output decode from the next state; the flags are registered below.
  always_comb begin
    in_ready_nxt_s  = (state_nxt_s == IDLE);
    busy_nxt_s      = (state_nxt_s != IDLE);
    out_valid_nxt_s = (state_nxt_s == DONE);
  end

  // Round datapath, handshake flags and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_r       <= '0;
      key_r       <= '0;
      rnd_r       <= '0;
      data_out_r  <= '0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      out_valid_r <= out_valid_nxt_s;
      in_ready_r  <= in_ready_nxt_s;
      busy_r      <= busy_nxt_s;
      if (accept_s) begin
        blk_r <= src_s ^ key_in;
        key_r <= key_in;
        rnd_r <= AES_RND_W'(1);
      end else if (state_r == RUN) begin
        blk_r <= st_chain_s[UNROLL];
        key_r <= key_chain_s[UNROLL];
        rnd_r <= finish_s ? AES_RND_W'(0) : rnd_r + AES_RND_W'(UNROLL);
      end
      if (finish_s) begin
        data_out_r <= out_blk_s;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign data_out  = data_out_r;

endmodule
